// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, with a
// one-entry registered response buffer carrying result, zero flag and owner ID.

package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_sel_t;
endpackage

module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] src1,
  input  logic [DWIDTH-1:0] src2,
  input  aluop_sel_t        sel,
  output logic [DWIDTH-1:0] res,
  output logic              res_is_0
);
  logic [4:0] shamt;
  assign shamt = src2[4:0];

  always_comb begin
    res = '0;
    case (sel)
      ALU_ADD:  res = src1 + src2;
      ALU_SUB:  res = src1 - src2;
      ALU_AND:  res = src1 & src2;
      ALU_OR:   res = src1 | src2;
      ALU_XOR:  res = src1 ^ src2;
      ALU_SLL:  res = src1 << shamt;
      ALU_SRL:  res = src1 >> shamt;
      ALU_SRA:  res = $signed(src1) >>> shamt;
      ALU_SLT:  res = {{(DWIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_SLTU: res = {{(DWIDTH-1){1'b0}}, (src1 < src2)};
      default:  res = '0;
    endcase
  end

  assign res_is_0 = (res == '0);
endmodule

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NREQ   = 2,
  parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_src1,
  input  logic [NREQ*DWIDTH-1:0] req_src2,
  input  aluop_sel_t [NREQ-1:0]  req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DWIDTH-1:0]      rsp_res,
  output logic                   rsp_res_is_0,
  output logic [15:0]            busy_cnt
);
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    ptr_next;
  logic              gnt_found;
  logic              accept;
  logic              grant;
  logic              stall;
  logic [DWIDTH-1:0] alu_src1;
  logic [DWIDTH-1:0] alu_src2;
  aluop_sel_t        alu_sel;
  logic [DWIDTH-1:0] alu_res;
  logic              alu_zero;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          gnt_found = 1'b1;
          gnt_idx   = IDW'(i);
        end
      end
    end
  end

  assign accept = !rsp_valid || rsp_ready;
  assign grant  = rst_n && accept && gnt_found;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = grant && (gnt_idx == IDW'(gi));
    end
  endgenerate

  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    alu_sel  = ALU_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        alu_src1 = req_src1[i*DWIDTH +: DWIDTH];
        alu_src2 = req_src2[i*DWIDTH +: DWIDTH];
        alu_sel  = req_op[i];
      end
    end
  end

  alu #(.DWIDTH(DWIDTH)) u_alu (
    .src1     (alu_src1),
    .src2     (alu_src2),
    .sel      (alu_sel),
    .res      (alu_res),
    .res_is_0 (alu_zero)
  );

  assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  // Any valid requester left without a grant this cycle counts as a stall.
  assign stall    = |(req_valid & ~req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_res      <= '0;
      rsp_res_is_0 <= 1'b0;
      busy_cnt     <= '0;
    end else begin
      if (grant) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= gnt_idx;
        rsp_res      <= alu_res;
        rsp_res_is_0 <= alu_zero;
        ptr          <= ptr_next;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (stall && (busy_cnt != 16'hFFFF)) begin
        busy_cnt <= busy_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter: a queue scoreboard fed at grant
// time, drained by an independent response monitor.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW   = 32;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_src1;
  logic [NREQ*DW-1:0]   req_src2;
  aluop_sel_t [NREQ-1:0] req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [DW-1:0]        rsp_res;
  logic                 rsp_res_is_0;
  logic [15:0]          busy_cnt;

  alu_arbiter #(.DWIDTH(DW), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_res      (rsp_res),
    .rsp_res_is_0 (rsp_res_is_0),
    .busy_cnt     (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              failures = 0;
  logic [NREQ-1:0] pend_valid = '0;
  logic [31:0]     pend_src1[NREQ];
  logic [31:0]     pend_src2[NREQ];
  aluop_sel_t      pend_op[NREQ];
  int              model_ptr = 0;
  bit              model_rsp_valid = 0;
  int              model_busy = 0;
  int              last_gnt = -1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_alu(aluop_sel_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic set_op(int i, aluop_sel_t op, logic [31:0] a, logic [31:0] b);
    pend_valid[i] = 1'b1;
    pend_op[i]    = op;
    pend_src1[i]  = a;
    pend_src2[i]  = b;
  endtask

  task automatic rand_op(int i);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom();
    b = ($urandom_range(0, 3) == 0) ? a : $urandom();
    set_op(i, aluop_sel_t'(4'($urandom_range(0, 15))), a, b);
  endtask

  task automatic apply();
    req_valid = pend_valid;
    for (int i = 0; i < NREQ; i++) begin
      req_src1[i*DW +: DW] = pend_src1[i];
      req_src2[i*DW +: DW] = pend_src2[i];
      req_op[i]            = pend_op[i];
    end
  endtask

  // One clock: drive, predict grant from the round-robin rule, check, advance.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_ready;
    exp_t e;
    apply();
    @(negedge clk);
    g = -1;
    exp_ready = '0;
    if (!model_rsp_valid || rsp_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (model_ptr + k) % NREQ;
        if (g < 0 && pend_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, model_rsp_valid);
    chk("busy_cnt", busy_cnt, model_busy);
    if (g >= 0) begin
      e.id   = g;
      e.res  = ref_alu(pend_op[g], pend_src1[g], pend_src2[g]);
      e.zero = (e.res == 32'd0);
      q.push_back(e);
    end
    if ((pend_valid & ~exp_ready) != '0 && model_busy < 65535) model_busy++;
    if (g >= 0) begin
      model_rsp_valid = 1;
      model_ptr = (g + 1) % NREQ;
    end else if (model_rsp_valid && rsp_ready) begin
      model_rsp_valid = 0;
    end
    last_gnt = g;
    @(posedge clk);
    #1;
    if (g >= 0) pend_valid[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_rsp_is_0", rsp_res_is_0, 0);
    chk("rst_busy_cnt", busy_cnt, 0);
    chk("rst_req_ready", req_ready, 0);
    q.delete();
    model_ptr = 0;
    model_rsp_valid = 0;
    model_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Response monitor: every presented response must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=id%0d required=no_response", rsp_id);
        end else begin
          e = q[0];
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_res", rsp_res, e.res);
          chk("rsp_res_is_0", rsp_res_is_0, e.zero);
          if (rsp_ready) begin
            void'(q.pop_front());
            $display("rsp id=%0d res=%h zero=%0b", rsp_id, rsp_res, rsp_res_is_0);
          end
        end
      end
    end
  end

  initial begin
    bit mid_reset_done;
    mid_reset_done = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, ALU_ADD, 32'd0, 32'd0);
    pend_valid = '0;
    apply();
    #3;
    do_reset();

    // Single requester: ADD then SUB giving zero.
    rsp_ready = 1'b1;
    set_op(0, ALU_ADD, 32'd5, 32'd7);
    step();
    chk("add_res", rsp_res, 32'd12);
    chk("add_id", rsp_id, 0);
    chk("add_is_0", rsp_res_is_0, 0);
    set_op(0, ALU_SUB, 32'd9, 32'd9);
    step();
    chk("sub_res", rsp_res, 32'd0);
    chk("sub_is_0", rsp_res_is_0, 1);

    // Signed compare and shift-amount truncation on requester 1.
    set_op(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("slt_res", rsp_res, 32'd1);
    set_op(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("sltu_res", rsp_res, 32'd0);
    set_op(1, ALU_SRA, 32'h8000_0000, 32'd33);
    step();
    chk("sra_res", rsp_res, 32'hC000_0000);
    step();

    // Backpressure: hold the buffer three cycles, then the other requester wins.
    set_op(0, ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
    step();
    rand_op(0);
    rand_op(1);
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    step();
    chk("bp_next_id", rsp_id, 1);
    pend_valid = '0;
    step();

    // Round-robin from ptr=0 with both requesters continuously valid.
    do_reset();
    rand_op(0);
    rand_op(1);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("rr_id", rsp_id, n % 2);
      if (last_gnt >= 0) rand_op(last_gnt);
    end
    chk("rr_busy", busy_cnt, 4);

    // Back-to-back: a fresh response every cycle.
    for (int n = 0; n < 8; n++) begin
      step();
      chk("b2b_valid", rsp_valid, 1);
      chk("b2b_id", rsp_id, last_gnt);
      if (last_gnt >= 0) rand_op(last_gnt);
    end
    pend_valid = '0;
    step();

    // Random traffic with one reset while a response is buffered.
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_valid[i] && $urandom_range(0, 99) < 60) rand_op(i);
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      if (it >= 150 && !mid_reset_done && model_rsp_valid) begin
        do_reset();
        mid_reset_done = 1;
      end
      step();
    end

    pend_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
